uart_rx_ctrl: RTL

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_rx_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx_ctrl.sv
// Oversampled UART receiver: synchronizes rx, hunts for a start edge on tick strobes,
// mid-bit samples DATA_BITS payload bits LSB first and hands frames over a valid/ready port.
module uart_rx_ctrl #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic [1:0]           sync_q, sync_d;
    logic                 rx_s;
    logic                 prev_q, prev_d;
    logic                 start_det;
    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 good_frame, bad_frame;
    logic [DATA_BITS-1:0] bit_sel;
    logic [DATA_BITS-1:0] shift_sampled;

    assign sync_d    = {sync_q[0], rx};
    assign rx_s      = sync_q[1];
    assign prev_d    = tick ? rx_s : prev_q;
    assign start_det = tick & prev_q & ~rx_s;

    // One-hot write strobe selecting the payload position of the current bit.
    generate
        for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_bit_sel
            assign bit_sel[gi] = (bit_idx_q == BIT_W'(gi));
        end
    endgenerate

    assign shift_sampled = (shift_q & ~bit_sel) | (bit_sel & {DATA_BITS{rx_s}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= 2'b11;
            prev_q      <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            prev_q      <= prev_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        good_frame = 1'b0;
        bad_frame  = 1'b0;
        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (start_det) begin
                        state_d = START;
                        cnt_d   = '0;
                    end
                end
                START: begin
                    // Start bit must still be low at its midpoint, else it was a glitch.
                    if (cnt_q == CNT_MID) begin
                        cnt_d = '0;
                        if (!rx_s) begin
                            state_d   = DATA;
                            bit_idx_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_END) begin
                        shift_d = shift_sampled;
                        cnt_d   = '0;
                        if (bit_idx_q == BIT_LAST) begin
                            state_d = STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + BIT_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cnt_q == CNT_END) begin
                        state_d    = IDLE;
                        cnt_d      = '0;
                        good_frame = rx_s;
                        bad_frame  = ~rx_s;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = bad_frame;
        overrun_d   = 1'b0;
        if (good_frame) begin
            // A same-cycle consume frees the holding register for the new payload.
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign busy      = (state_q != IDLE);
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule
